// File: rtl/instr_byte_assembler.sv
// Groups a fetched byte stream into 1-3 byte 6502 instructions for the decoder.
// Optional illegal-opcode trapping is enabled with `define ILLEGAL_OPCODE_TRAP_EN.
module instr_byte_assembler #(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  input  logic [PC_W-1:0] in_pc,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_opcode,
  output logic [15:0]     out_operand,
  output logic [1:0]      out_len,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {S_OPC, S_LO, S_HI} state_t;

  state_t          state_q, state_d;
  logic [7:0]      op_q, lo_q;
  logic [1:0]      len_q;
  logic [PC_W-1:0] pc_q;
  logic            ill_q;

  logic            accept, handoff;
  logic            in_illegal;
  logic [1:0]      in_len;

  logic            load;
  logic [7:0]      ld_op;
  logic [15:0]     ld_operand;
  logic [1:0]      ld_len;
  logic [PC_W-1:0] ld_pc;
  logic            ld_ill;

`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign in_illegal = (in_data[1:0] == 2'b11) ||
                      ((in_data[3:0] == 4'h2) && (in_data != 8'hA2));
`else
  assign in_illegal = 1'b0;
`endif

  // Illegal opcodes are issued as single bytes so the stream resynchronises.
  always_comb begin
    in_len = 2'd2;
    if (in_illegal ||
        (in_data[3:0] == 4'h8) || (in_data[3:0] == 4'hA) ||
        (in_data == 8'h00) || (in_data == 8'h40) || (in_data == 8'h60))
      in_len = 2'd1;
    else if ((in_data[3:0] >= 4'hC) ||
             (((in_data[3:0] == 4'h9) || (in_data[3:0] == 4'hB)) && in_data[4]) ||
             (in_data == 8'h20))
      in_len = 2'd3;
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready && !flush;

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    ld_op      = op_q;
    ld_operand = {8'h00, lo_q};
    ld_len     = len_q;
    ld_pc      = pc_q;
    ld_ill     = ill_q;
    unique case (state_q)
      S_OPC: if (accept) begin
        if (in_len == 2'd1) begin
          load       = 1'b1;
          ld_op      = in_data;
          ld_operand = '0;
          ld_len     = 2'd1;
          ld_pc      = in_pc;
          ld_ill     = in_illegal;
        end else begin
          state_d = S_LO;
        end
      end
      S_LO: if (accept) begin
        if (len_q == 2'd2) begin
          load       = 1'b1;
          ld_operand = {8'h00, in_data};
          state_d    = S_OPC;
        end else begin
          state_d = S_HI;
        end
      end
      S_HI: if (accept) begin
        load       = 1'b1;
        ld_operand = {in_data, lo_q};
        state_d    = S_OPC;
      end
      default: state_d = S_OPC;
    endcase
    if (flush) begin
      state_d = S_OPC;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_OPC;
      op_q    <= '0;
      lo_q    <= '0;
      len_q   <= '0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == S_OPC) begin
        op_q  <= in_data;
        pc_q  <= in_pc;
        len_q <= in_len;
        ill_q <= in_illegal;
        lo_q  <= '0;
      end
      if (accept && state_q == S_LO)
        lo_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_operand <= '0;
      out_len     <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (load)
        out_valid <= 1'b1;
      else if (handoff)
        out_valid <= 1'b0;
      if (load) begin
        out_opcode  <= ld_op;
        out_operand <= ld_operand;
        out_len     <= ld_len;
        out_pc      <= ld_pc;
        out_illegal <= ld_ill;
      end
      if (handoff)
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule
